// File: rtl/ghost_collision.sv
// Ghost contact detector with life/grace/game-over state machine and blink control.
// Optional GHOST_PIXEL_HIT_EN: pixel-accurate contact evaluated once per frame.
module ghost_collision #(
    parameter int SPRITE_W    = 16,
    parameter int INSET       = 3,
    parameter int LIVES_INIT  = 3,
    parameter int GRACE_TICKS = 100000000,
    parameter int BLINK_TICKS = 6250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] y_x,
    input  logic [9:0] y_y,
    input  logic [9:0] g_t_x,
    input  logic [9:0] g_t_y,
    input  logic [9:0] g_b_x,
    input  logic [9:0] g_b_y,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       yoshi_on,
    input  logic       ghost_top_on,
    input  logic       ghost_bottom_on,
    output logic       hit,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       blink,
    output logic       grace
);
    typedef enum logic [1:0] {ALIVE, GRACE, GAME_OVER} state_t;

    localparam int GC_W = $clog2(GRACE_TICKS + 1);
    localparam int BC_W = $clog2(BLINK_TICKS + 1);

    logic contact_q;

`ifdef GHOST_PIXEL_HIT_EN
    logic frame_hit_q;
    logic px_hit;
    logic eval_pt;
    logic unused_pos;

    assign px_hit     = yoshi_on && (ghost_top_on || ghost_bottom_on);
    assign eval_pt    = (x == 10'd0) && (y == 10'd480);
    assign unused_pos = ^{y_x, y_y, g_t_x, g_t_y, g_b_x, g_b_y};

    // contact only changes at the start of vertical blank, one decision per frame
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_hit_q <= 1'b0;
            contact_q   <= 1'b0;
        end else if (eval_pt) begin
            frame_hit_q <= 1'b0;
            contact_q   <= frame_hit_q | px_hit;
        end else begin
            frame_hit_q <= frame_hit_q | px_hit;
        end
    end
`else
    localparam logic [10:0] SW = 11'(SPRITE_W);
    localparam logic [10:0] IN = 11'(INSET);

    logic contact_d;
    logic unused_pix;

    // 11-bit compare so boxes near the right/bottom edge never wrap
    function automatic logic box_overlap(input logic [9:0] ax, input logic [9:0] ay,
                                         input logic [9:0] bx, input logic [9:0] by);
        logic [10:0] ax1, ay1, bx1, by1;
        ax1 = {1'b0, ax};
        ay1 = {1'b0, ay};
        bx1 = {1'b0, bx};
        by1 = {1'b0, by};
        return ((ax1 + IN) < (bx1 + SW - IN)) && ((bx1 + IN) < (ax1 + SW - IN)) &&
               ((ay1 + IN) < (by1 + SW - IN)) && ((by1 + IN) < (ay1 + SW - IN));
    endfunction

    assign contact_d  = box_overlap(y_x, y_y, g_t_x, g_t_y) | box_overlap(y_x, y_y, g_b_x, g_b_y);
    assign unused_pix = ^{x, y, yoshi_on, ghost_top_on, ghost_bottom_on};

    always_ff @(posedge clk) begin
        if (reset) contact_q <= 1'b0;
        else       contact_q <= contact_d;
    end
`endif

    state_t          state_q;
    logic [1:0]      lives_q;
    logic            hit_q;
    logic            game_over_q;
    logic            grace_q;
    logic            blink_q;
    logic [GC_W-1:0] grace_cnt_q;
    logic [BC_W-1:0] blink_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ALIVE;
            lives_q     <= 2'(LIVES_INIT);
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            grace_q     <= 1'b0;
            blink_q     <= 1'b1;
            grace_cnt_q <= '0;
            blink_cnt_q <= '0;
        end else begin
            hit_q <= 1'b0;
            case (state_q)
                ALIVE: begin
                    if (contact_q) begin
                        hit_q       <= 1'b1;
                        lives_q     <= lives_q - 2'd1;
                        grace_cnt_q <= '0;
                        blink_cnt_q <= '0;
                        blink_q     <= 1'b1;
                        if (lives_q == 2'd1) begin
                            state_q     <= GAME_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q <= GRACE;
                            grace_q <= 1'b1;
                        end
                    end
                end
                GRACE: begin
                    if (grace_cnt_q == GC_W'(GRACE_TICKS - 1)) begin
                        state_q     <= ALIVE;
                        grace_q     <= 1'b0;
                        blink_q     <= 1'b1;
                        grace_cnt_q <= '0;
                        blink_cnt_q <= '0;
                    end else begin
                        grace_cnt_q <= grace_cnt_q + 1'b1;
                        if (blink_cnt_q == BC_W'(BLINK_TICKS - 1)) begin
                            blink_cnt_q <= '0;
                            blink_q     <= ~blink_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    // terminal until reset
                    state_q     <= GAME_OVER;
                    lives_q     <= 2'd0;
                    game_over_q <= 1'b1;
                    grace_q     <= 1'b0;
                    blink_q     <= 1'b1;
                end
            endcase
        end
    end

    assign hit       = hit_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;
    assign grace     = grace_q;
    assign blink     = blink_q;
endmodule

// File: tb/tb_ghost_collision.sv
// Bench for ghost_collision: directed scenarios plus randomized run against a cycle model.
module tb_ghost_collision;
    localparam int S = 16, I = 3, L = 3, G = 20, B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] y_x = 10'd100, y_y = 10'd100;
    logic [9:0] g_t_x = 10'd620, g_t_y = 10'd460, g_b_x = 10'd300, g_b_y = 10'd20;
    logic [9:0] px = '0, py = '0;
    logic yon = 1'b0, gton = 1'b0, gbon = 1'b0;
    logic hit, game_over, blink, grace;
    logic [1:0] lives;

    int checks = 0;
    int errors = 0;

    ghost_collision #(.SPRITE_W(S), .INSET(I), .LIVES_INIT(L), .GRACE_TICKS(G), .BLINK_TICKS(B)) dut (
        .clk(clk), .reset(rst),
        .y_x(y_x), .y_y(y_y), .g_t_x(g_t_x), .g_t_y(g_t_y), .g_b_x(g_b_x), .g_b_y(g_b_y),
        .x(px), .y(py), .yoshi_on(yon), .ghost_top_on(gton), .ghost_bottom_on(gbon),
        .hit(hit), .lives(lives), .game_over(game_over), .blink(blink), .grace(grace)
    );

    always #5 clk = ~clk;

    // reference model: registered contact, lives, game-over flag, cycles spent in grace
    bit m_c, m_hit, m_over, m_gr;
    int m_lives, m_k;

    function automatic bit ov(int ax, int ay, int bx, int by);
        int dx, dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return (dx < S - 2 * I) && (dy < S - 2 * I);
    endfunction

    function automatic bit exp_blink();
        return m_gr ? ((m_k / B) % 2 == 0) : 1'b1;
    endfunction

    task automatic model_step();
        bit nc;
        nc = ov(y_x, y_y, g_t_x, g_t_y) || ov(y_x, y_y, g_b_x, g_b_y);
        if (rst) begin
            m_lives = L; m_over = 0; m_gr = 0; m_k = 0; m_hit = 0; nc = 0;
        end else begin
            m_hit = 0;
            if (m_over) begin
            end else if (m_gr) begin
                if (m_k == G - 1) begin m_gr = 0; m_k = 0; end
                else m_k++;
            end else if (m_c) begin
                m_hit = 1;
                m_lives--;
                if (m_lives == 0) m_over = 1;
                else begin m_gr = 1; m_k = 0; end
            end
        end
        m_c = nc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ghosts_away();
        g_t_x = 10'd620; g_t_y = 10'd460; g_b_x = 10'd300; g_b_y = 10'd20;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        ghosts_away();
        rst = 1'b1; tick(); tick();
        checks++;
        if (hit !== 1'b0 || lives !== 2'd3 || game_over !== 1'b0 || grace !== 1'b0 || blink !== 1'b1) begin
            errors++;
            $display("FAIL reset: hit=%b lives=%0d go=%b grace=%b blink=%b exp 0 3 0 0 1",
                     hit, lives, game_over, grace, blink);
        end
        rst = 1'b0;
    endtask

    task automatic test_no_contact();
        int nh = 0;
        y_x = 10'd100; y_y = 10'd100; ghosts_away();
        for (int c = 0; c < 100; c++) begin
            px = 10'($urandom_range(0, 799)); py = 10'($urandom_range(0, 524));
            yon = 1'($urandom); gton = 1'($urandom); gbon = 1'($urandom);
            tick();
            if (hit) nh++;
        end
        yon = 0; gton = 0; gbon = 0;
        checks++;
        if (nh != 0 || lives !== 2'd3 || blink !== 1'b1 || grace !== 1'b0) begin
            errors++;
            $display("FAIL no_contact: hits=%0d lives=%0d blink=%b grace=%b exp 0 3 1 0", nh, lives, blink, grace);
        end
    endtask

    task automatic test_edge_touch();
        int tx[4] = '{110, 100, 90, 109};
        int ty[4] = '{100, 110, 100, 100};
        bit eh[4] = '{0, 0, 0, 1};
        for (int p = 0; p < 4; p++) begin
            int nh = 0;
            g_t_x = 10'(tx[p]); g_t_y = 10'(ty[p]);
            for (int c = 0; c < 2; c++) begin tick(); if (hit) nh++; end
            checks++;
            if ((nh != 0) !== eh[p]) begin
                errors++;
                $display("FAIL edge_touch(%0d,%0d): hits=%0d exp_hit=%0d", tx[p], ty[p], nh, eh[p]);
            end
            if (!eh[p]) repeat (4) tick();
        end
        checks++;
        if (lives !== 2'd2) begin
            errors++;
            $display("FAIL edge_lives: got %0d exp 2", lives);
        end
        ghosts_away();
        do_reset();
    endtask

    task automatic test_hit_blink();
        g_b_x = 10'd105; g_b_y = 10'd105;
        tick();
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL hit_early: hit=%b exp 0", hit); end
        tick();
        checks++;
        if (hit !== 1'b1 || lives !== 2'd2 || grace !== 1'b1 || blink !== 1'b1) begin
            errors++;
            $display("FAIL first_hit: hit=%b lives=%0d grace=%b blink=%b exp 1 2 1 1", hit, lives, grace, blink);
        end
        for (int k = 1; k < G; k++) begin
            bit eb;
            eb = ((k / B) % 2 == 0);
            tick();
            checks++;
            if (hit !== 1'b0 || grace !== 1'b1 || blink !== eb) begin
                errors++;
                $display("FAIL grace_blink k=%0d: hit=%b grace=%b blink=%b exp 0 1 %b", k, hit, grace, blink, eb);
            end
        end
    endtask

    task automatic test_grace_rehit();
        tick();
        checks++;
        if (hit !== 1'b0 || grace !== 1'b0 || blink !== 1'b1) begin
            errors++;
            $display("FAIL grace_exit: hit=%b grace=%b blink=%b exp 0 0 1", hit, grace, blink);
        end
        tick();
        checks++;
        if (hit !== 1'b1 || lives !== 2'd1) begin
            errors++;
            $display("FAIL rehit: hit=%b lives=%0d exp 1 1", hit, lives);
        end
        ghosts_away();
        repeat (G + 3) tick();
        checks++;
        if (grace !== 1'b0 || lives !== 2'd1 || hit !== 1'b0) begin
            errors++;
            $display("FAIL post_grace: grace=%b lives=%0d hit=%b exp 0 1 0", grace, lives, hit);
        end
    endtask

    task automatic test_double_gameover();
        int nh = 0;
        g_t_x = 10'd105; g_t_y = 10'd105; g_b_x = 10'd95; g_b_y = 10'd95;
        tick(); tick();
        checks++;
        if (hit !== 1'b1 || lives !== 2'd0 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL double_hit: hit=%b lives=%0d go=%b exp 1 0 1", hit, lives, game_over);
        end
        for (int c = 0; c < 30; c++) begin tick(); if (hit) nh++; end
        checks++;
        if (nh != 0 || lives !== 2'd0 || game_over !== 1'b1 || blink !== 1'b1 || grace !== 1'b0) begin
            errors++;
            $display("FAIL game_over_hold: hits=%0d lives=%0d go=%b blink=%b grace=%b exp 0 0 1 1 0",
                     nh, lives, game_over, blink, grace);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (lives !== 2'd3 || game_over !== 1'b0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL go_reset: lives=%0d go=%b hit=%b exp 3 0 0", lives, game_over, hit);
        end
        ghosts_away();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                y_x = 10'($urandom);
                y_y = 10'($urandom);
                g_t_x = 10'(int'(y_x) + $urandom_range(0, 24) - 12);
                g_t_y = 10'(int'(y_y) + $urandom_range(0, 24) - 12);
                g_b_x = 10'(int'(y_x) + $urandom_range(0, 40) - 20);
                g_b_y = 10'(int'(y_y) + $urandom_range(0, 40) - 20);
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (hit !== m_hit || lives !== 2'(m_lives) || game_over !== m_over ||
                grace !== m_gr || blink !== exp_blink()) begin
                errors++;
                $display("FAIL random c=%0d: hit=%b lives=%0d go=%b grace=%b blink=%b exp %b %0d %b %b %b",
                         c, hit, lives, game_over, grace, blink, m_hit, m_lives, m_over, m_gr, exp_blink());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_contact();
        test_edge_touch();
        test_hit_blink();
        test_grace_rehit();
        test_double_gameover();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
